// File: rtl/nco_cfg_arbiter_if.sv
// Requester-side and NCO-side signal bundle for nco_cfg_arbiter.
// The arbiter connects through the slave modport; requesters/NCO model drive via master.
interface nco_cfg_arbiter_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned FRE_MOD_WIDTH = 32,
  parameter int unsigned PHA_MOD_WIDTH = 32
);
  logic [NUM_REQ-1:0]               req;
  logic [2*NUM_REQ-1:0]             req_mode;
  logic [NUM_REQ*FRE_MOD_WIDTH-1:0] req_freq;
  logic [NUM_REQ*PHA_MOD_WIDTH-1:0] req_phase;
  logic [NUM_REQ-1:0]               req_ack;
  logic                             req_err;
  logic                             busy;
  logic [FRE_MOD_WIDTH-1:0]         cfg_freq;
  logic [PHA_MOD_WIDTH-1:0]         cfg_phase;
  logic [1:0]                       cfg_ctl;
  logic                             nco_done;
  logic [2:0]                       grant_id;

  modport master (
    output req, req_mode, req_freq, req_phase, nco_done,
    input  req_ack, req_err, busy, cfg_freq, cfg_phase, cfg_ctl, grant_id
  );

  modport slave (
    input  req, req_mode, req_freq, req_phase, nco_done,
    output req_ack, req_err, busy, cfg_freq, cfg_phase, cfg_ctl, grant_id
  );
endinterface

// File: rtl/nco_cfg_arbiter.sv
// Round-robin arbiter sharing one NCO configuration port among NUM_REQ requesters.
// Optional WAIT timeout enabled by defining NCO_CFG_TIMEOUT_EN.
module nco_cfg_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned FRE_MOD_WIDTH = 32,
  parameter int unsigned PHA_MOD_WIDTH = 32,
  parameter int unsigned TMO_WIDTH     = 12
) (
  input logic             CLK,
  input logic             nRST,
  nco_cfg_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("nco_cfg_arbiter: NUM_REQ must be 2..8");
  end
  if (TMO_WIDTH < 2) begin : g_bad_tmo_width
    $error("nco_cfg_arbiter: TMO_WIDTH must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  state_t                   state_q;
  logic [2:0]               ptr_q;
  logic [2:0]               grant_q;
  logic [1:0]               mode_q;
  logic [1:0]               cfg_ctl_q;
  logic [FRE_MOD_WIDTH-1:0] freq_q;
  logic [PHA_MOD_WIDTH-1:0] phase_q;
  logic [NUM_REQ-1:0]       ack_q;
  logic                     err_q;
  logic                     busy_q;

`ifdef NCO_CFG_TIMEOUT_EN
  logic [TMO_WIDTH-1:0]     tmo_q;
  logic [TMO_WIDTH-1:0]     tmo_d;
  assign tmo_d = tmo_q + 1'b1;
`endif

  logic                     pick_vld;
  logic [2:0]               pick_id;
  logic [1:0]               sel_mode;
  logic [FRE_MOD_WIDTH-1:0] sel_freq;
  logic [PHA_MOD_WIDTH-1:0] sel_phase;
  logic [NUM_REQ-1:0]       grant_onehot;
  logic [2:0]               ptr_d;

  // First set request at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && bus.req[(32'(ptr_q) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_id  = 3'((32'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign sel_mode     = bus.req_mode[2*grant_q +: 2];
  assign sel_freq     = bus.req_freq[grant_q*FRE_MOD_WIDTH +: FRE_MOD_WIDTH];
  assign sel_phase    = bus.req_phase[grant_q*PHA_MOD_WIDTH +: PHA_MOD_WIDTH];
  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign ptr_d        = (grant_q == 3'(NUM_REQ-1)) ? '0 : grant_q + 3'd1;

  // The strobe is launched from the live slice so it coincides with ISSUE;
  // the illegal-mode decision is taken on the latched mode register in ISSUE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      mode_q    <= '0;
      cfg_ctl_q <= '0;
      freq_q    <= '0;
      phase_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef NCO_CFG_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_id;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          freq_q    <= sel_freq;
          phase_q   <= sel_phase;
          mode_q    <= sel_mode;
          cfg_ctl_q <= sel_mode;
          state_q   <= ISSUE;
        end
        ISSUE: begin
          cfg_ctl_q <= '0;
`ifdef NCO_CFG_TIMEOUT_EN
          tmo_q     <= '0;
`endif
          if (mode_q == 2'b00) begin
            ack_q   <= grant_onehot;
            err_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cfg_ctl_q <= '0;
          if (bus.nco_done) begin
            ack_q   <= grant_onehot;
            err_q   <= 1'b0;
            state_q <= ACK;
          end
`ifdef NCO_CFG_TIMEOUT_EN
          else if (&tmo_d) begin
            ack_q   <= grant_onehot;
            err_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            tmo_q   <= tmo_d;
          end
`endif
        end
        ACK: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.req_err   = err_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_freq  = freq_q;
  assign bus.cfg_phase = phase_q;
  assign bus.cfg_ctl   = cfg_ctl_q;
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_nco_cfg_arbiter.sv
// Directed self-checking bench for nco_cfg_arbiter (4 requesters, 32-bit words).
module tb_nco_cfg_arbiter;

  logic clk;
  logic nrst;
  int   n_tests;
  int   n_fail;

  nco_cfg_arbiter_if #(.NUM_REQ(4), .FRE_MOD_WIDTH(32), .PHA_MOD_WIDTH(32)) bus ();

  nco_cfg_arbiter #(
    .NUM_REQ(4),
    .FRE_MOD_WIDTH(32),
    .PHA_MOD_WIDTH(32),
    .TMO_WIDTH(4)
  ) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"},   64'(bus.req_ack),   64'h0);
    chk({tag, "_err"},   64'(bus.req_err),   64'h0);
    chk({tag, "_busy"},  64'(bus.busy),      64'h0);
    chk({tag, "_freq"},  64'(bus.cfg_freq),  64'h0);
    chk({tag, "_phase"}, 64'(bus.cfg_phase), 64'h0);
    chk({tag, "_ctl"},   64'(bus.cfg_ctl),   64'h0);
    chk({tag, "_gid"},   64'(bus.grant_id),  64'h0);
  endtask

  initial begin
    int seen;
    int bad;
    int cyc;
    n_tests       = 0;
    n_fail        = 0;
    nrst          = 1'b0;
    bus.req       = '0;
    bus.req_mode  = '0;
    bus.req_freq  = '0;
    bus.req_phase = '0;
    bus.nco_done  = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle_outputs("reset");
    nrst = 1'b1;
    tick();

    // Single request on requester 1, freq update
    bus.req_mode[3:2]   = 2'b01;
    bus.req_freq[63:32] = 32'h12345678;
    bus.req             = 4'b0010;           // cycle N
    tick();                                   // N+1
    chk("single_busy", 64'(bus.busy), 64'h1);
    chk("single_gid", 64'(bus.grant_id), 64'h1);
    chk("single_ctl_n1", 64'(bus.cfg_ctl), 64'h0);
    tick();                                   // N+2
    chk("single_ctl", 64'(bus.cfg_ctl), 64'h1);
    chk("single_freq", 64'(bus.cfg_freq), 64'h12345678);
    tick();                                   // N+3
    chk("single_ctl_off", 64'(bus.cfg_ctl), 64'h0);
    tick();                                   // N+4
    chk("single_no_early_ack", 64'(bus.req_ack), 64'h0);
    bus.nco_done = 1'b1;
    tick();                                   // N+5
    bus.nco_done = 1'b0;
    chk("single_ack", 64'(bus.req_ack), 64'h2);
    chk("single_err", 64'(bus.req_err), 64'h0);
    bus.req = '0;
    tick();
    chk("single_ack_pulse", 64'(bus.req_ack), 64'h0);
    chk("single_busy_off", 64'(bus.busy), 64'h0);
    chk("single_freq_hold", 64'(bus.cfg_freq), 64'h12345678);

    // Illegal mode on requester 2
    bus.req_mode[5:4] = 2'b00;
    bus.req           = 4'b0100;             // N
    tick();                                   // N+1
    chk("illegal_gid", 64'(bus.grant_id), 64'h2);
    tick();                                   // N+2
    chk("illegal_no_strobe", 64'(bus.cfg_ctl), 64'h0);
    chk("illegal_no_early_ack", 64'(bus.req_ack), 64'h0);
    tick();                                   // N+3
    chk("illegal_ack", 64'(bus.req_ack), 64'h4);
    chk("illegal_err", 64'(bus.req_err), 64'h1);
    chk("illegal_ctl", 64'(bus.cfg_ctl), 64'h0);
    bus.req = '0;
    tick();
    chk("illegal_busy_off", 64'(bus.busy), 64'h0);

    // Phase change after LOAD must not disturb the transaction
    bus.req_mode[1:0]  = 2'b10;
    bus.req_phase[31:0] = 32'hAAAA0000;
    bus.req            = 4'b0001;            // N
    tick();                                   // N+1
    tick();                                   // N+2
    bus.req_phase[31:0] = 32'h00005555;
    chk("dchg_ctl", 64'(bus.cfg_ctl), 64'h2);
    chk("dchg_phase_n2", 64'(bus.cfg_phase), 64'hAAAA0000);
    tick();                                   // N+3
    bus.nco_done = 1'b1;
    tick();                                   // N+4
    bus.nco_done = 1'b0;
    chk("dchg_ack", 64'(bus.req_ack), 64'h1);
    chk("dchg_phase_ack", 64'(bus.cfg_phase), 64'hAAAA0000);
    bus.req = '0;
    tick();

    // Reset during WAIT on requester 3
    bus.req_mode[7:6]    = 2'b11;
    bus.req_freq[127:96] = 32'hCAFEF00D;
    bus.req              = 4'b1000;          // N
    tick();
    tick();
    chk("rstw_ctl", 64'(bus.cfg_ctl), 64'h3);
    chk("rstw_gid", 64'(bus.grant_id), 64'h3);
    tick();                                   // WAIT
    #2;
    nrst = 1'b0;
    #1;
    chk_idle_outputs("rstw");
    bus.req = '0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.req_ack != '0) bad++;
    end
    chk("rstw_no_ack", 64'(bad), 64'h0);
    nrst = 1'b1;
    tick();

    // Contention: all four hold requests; expect 0,1,2,3,0 from pointer 0
    bus.req_mode = 8'b01_01_01_01;
    bus.req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      seen = 0;
      for (int t = 0; t < 20 && seen == 0; t++) begin
        tick();
        if (bus.cfg_ctl != 2'b00) seen = 1;
      end
      chk($sformatf("cont_strobe_%0d", k), 64'(seen), 64'h1);
      tick();
      bus.nco_done = 1'b1;
      tick();
      bus.nco_done = 1'b0;
      chk($sformatf("cont_ack_%0d", k), 64'(bus.req_ack), 64'(4'b0001 << (k % 4)));
      chk($sformatf("cont_gid_%0d", k), 64'(bus.grant_id), 64'(k % 4));
      chk($sformatf("cont_err_%0d", k), 64'(bus.req_err), 64'h0);
    end
    bus.req = '0;
    tick();
    tick();

    // No nco_done: timeout when enabled, indefinite hold otherwise
    bus.req_mode[1:0] = 2'b01;
    bus.req           = 4'b0001;             // N
    tick();
    tick();
    chk("hold_strobe", 64'(bus.cfg_ctl), 64'h1);
    tick();                                   // WAIT entered
`ifdef NCO_CFG_TIMEOUT_EN
    cyc  = 0;
    seen = 0;
    for (int t = 0; t < 40 && seen == 0; t++) begin
      tick();
      cyc++;
      if (bus.req_ack != '0) seen = 1;
    end
    chk("tmo_seen", 64'(seen), 64'h1);
    chk("tmo_cycles", 64'(cyc), 64'd15);
    chk("tmo_ack", 64'(bus.req_ack), 64'h1);
    chk("tmo_err", 64'(bus.req_err), 64'h1);
`else
    bad = 0;
    cyc = 0;
    for (int t = 0; t < 1000; t++) begin
      tick();
      cyc++;
      if (bus.busy !== 1'b1 || bus.req_ack != '0 || bus.cfg_ctl != '0) bad++;
    end
    chk("hold_bad_cycles", 64'(bad), 64'h0);
    chk("hold_cycles", 64'(cyc), 64'd1000);
`endif
    bus.req = '0;
    nrst    = 1'b0;
    tick();
    chk("final_reset_busy", 64'(bus.busy), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
